// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice reused across NIBBLES cycles, LSB nibble first.
// Latency NIBBLES+1 cycles from accept to out_valid; holds result in DONE until out_ready, accepts only in IDLE.

module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);
        s_o    = p ^ c[3:0];
        cout_o = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [3:0]        cla_s;
    logic              cla_cout;

    cla_4bit u_cla (
        .a_i    (a_sh_q[3:0]),
        .b_i    (b_sh_q[3:0]),
        .cin_i  (carry_q),
        .s_o    (cla_s),
        .cout_o (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = cla_cout;
                // Each new nibble enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
                sum_d   = (sum_q >> 4) | (WIDTH'(cla_s) << (WIDTH - 4));
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    cout_d  = cla_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [3:0]  sum4;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb16[$];
    logic [4:0]  sb4[$];

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int n = 0;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        while (!in_ready && n < 20) begin tick(); n++; end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        sb16.push_back({1'b0, av} + {1'b0, bv} + {16'd0, cv});
    endtask

    task automatic wait_out16(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin tick(); edges++; end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic check_pop16(input string name);
        logic [16:0] exp;
        checks++;
        if (sb16.size() == 0) begin
            errors++;
            $display("FAIL %s: result with empty scoreboard, got %h", name, {cout, sum});
        end else begin
            exp = sb16.pop_front();
            if ({cout, sum} !== exp) begin
                errors++;
                $display("FAIL %s: {cout,sum}=%h required %h", name, {cout, sum}, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset16: rdy/vld/busy/cout/sum=%b%b%b%b/%h required 1000/0000",
                     in_ready, out_valid, busy, cout, sum);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4, cout4, sum4} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset4: got %b required 10000000",
                     {in_ready4, out_valid4, busy4, cout4, sum4});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_carry_ripple();
        int edges;
        out_ready = 1'b0;
        accept16(16'hFFFF, 16'h0001, 1'b0);
        wait_out16(edges);
        check_pop16("ripple_sum");
        checks++;
        if ({cout, sum} !== 17'h1_0000) begin
            errors++;
            $display("FAIL ripple_abs: {cout,sum}=%h required 10000", {cout, sum});
        end
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL done_flags: in_ready/busy=%b%b required 01", in_ready, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy, cout, sum} !== {3'b010, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL release: vld/rdy/busy/cout/sum=%b%b%b%b/%h required 0101/0000",
                     out_valid, in_ready, busy, cout, sum);
        end
    endtask

    task automatic test_latency();
        int edges;
        accept16(16'h1234, 16'h4321, 1'b1);
        wait_out16(edges);
        checks++;
        if (edges != 4) begin
            errors++;
            $display("FAIL latency16: out_valid after %0d edges required 4", edges);
        end
        check_pop16("sum_5556");
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int edges;
        logic [16:0] held;
        accept16(16'hABCD, 16'h1111, 1'b0);
        wait_out16(edges);
        held = {cout, sum};
        check_pop16("bp_sum");
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            a = 16'h5A5A ^ 16'(i); b = 16'h0F0F; cin = 1'b1;
            tick();
            checks++;
            if ({out_valid, in_ready, cout, sum} !== {2'b10, held}) begin
                errors++;
                $display("FAIL backpressure_%0d: vld/rdy=%b%b {cout,sum}=%h required 10 %h",
                         i, out_valid, in_ready, {cout, sum}, held);
            end
        end
        // in_valid stays high across the DONE->IDLE edge: must not be accepted there.
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL no_back_to_back: busy/rdy/vld=%b%b%b required 010",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        accept16(16'h8765, 16'h4321, 1'b1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb16.delete();
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {3'b100, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid_run: rdy/vld/busy/cout/sum=%b%b%b%b/%h required 1000/0000",
                     in_ready, out_valid, busy, cout, sum);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_result_%0d: out_valid=%b busy=%b required 0 0",
                         i, out_valid, busy);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int accepts = 0;
        int results = 0;
        int n;
        bit done;
        for (int i = 0; i < 1000; i++) begin
            accept16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            accepts++;
            done = 1'b0;
            n = 0;
            while (!done && n < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check_pop16("random_sum");
                    results++;
                    done = 1'b1;
                end
                tick();
                n++;
            end
            out_ready = 1'b0;
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL random_timeout: iteration %0d got no result", i);
            end
        end
        checks++;
        if (results != accepts || sb16.size() != 0) begin
            errors++;
            $display("FAIL random_count: results=%0d required %0d (left %0d)",
                     results, accepts, sb16.size());
        end
    endtask

    task automatic test_width4();
        int edges = 0;
        logic [4:0] exp;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; in_valid4 = 1'b1;
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL w4_ready: in_ready=%b required 1", in_ready4);
        end
        tick();
        in_valid4 = 1'b0;
        sb4.push_back({1'b0, 4'hF} + {1'b0, 4'hF} + 5'd1);
        while (!out_valid4 && edges < 10) begin tick(); edges++; end
        checks++;
        if (!out_valid4 || edges != 1) begin
            errors++;
            $display("FAIL w4_latency: out_valid=%b after %0d edges required 1 after 1",
                     out_valid4, edges);
        end
        exp = sb4.pop_front();
        checks++;
        if ({cout4, sum4} !== exp) begin
            errors++;
            $display("FAIL w4_sum: {cout,sum}=%h required %h", {cout4, sum4}, exp);
        end
        out_ready4 = 1'b1; tick(); out_ready4 = 1'b0;
        checks++;
        if ({out_valid4, in_ready4} !== 2'b01) begin
            errors++;
            $display("FAIL w4_release: vld/rdy=%b%b required 01", out_valid4, in_ready4);
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_latency();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
